clk_divider_bank: RTL and testbench
===================================

# clk_divider_bank

Multi-channel programmable clock divider, successor to the single-channel N-divider. N_CH independent channels each produce a divided clock with programmable period and high-time (duty cycle), plus a one-cycle period-start tick. Divisor/high-time updates are double-buffered and take effect only at a period boundary, so the outputs never glitch. A global sync input phase-aligns all channels. It sits beside the lab top level and provides slow clocks and enables for downstream logic.

## Interface
- N_CH, 4: number of channels.
- CNT_W, 32: width of the divisor, high-time and internal counter.
- RESET_DIV, 2: active divisor of every channel after reset.
- RESET_HIGH, 1: active high-time of every channel after reset.

- inclk  in  1  source clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable  in  N_CH  per-channel run enable.
- sync  in  1  global phase-align strobe, one cycle.
- load  in  N_CH  per-channel shadow-load strobe.
- divisor  in  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]; period in inclk cycles.
- high  in  N_CH*CNT_W  channel i at [i*CNT_W +: CNT_W]; high cycles per period.
- outclk  out  N_CH  divided clock, registered.
- tick  out  N_CH  one-cycle pulse in the first cycle of each period.
- pending  out  N_CH  shadow holds a value not yet applied.

## Operation
- Per channel: active regs D, H; shadow regs SD, SH; counter cnt (CNT_W); pending flag.
- "Apply" means: if pending, D<=SD, H<=SH, pending<=0; else D, H unchanged. D' and H' below denote the post-apply values.
- Per-channel next-state, priority order, each rising edge of inclk:
  - enable=0: apply; cnt<=D'-1 (0 if D'<=1); outclk<=0; tick<=0.
  - sync=1 or wrap (cnt==D-1, or D<=1): apply; cnt<=0; tick<=1; outclk<=(H'!=0).
  - otherwise: cnt<=cnt+1; tick<=0; outclk<=(cnt+1 < H).
- As a result, outclk is high exactly in the cycles where cnt<H. H=0 gives outclk constant 0. H>=D gives outclk constant 1 while enabled.
- D=0 and D=1 are equivalent: cnt stays 0, tick is high every enabled cycle, and outclk=(H!=0).
- A load[i] edge writes SD/SH from the buses and sets pending<=1. Load has priority over apply on the same edge: the boundary applies the old shadow (if any), then the new value is captured and pending remains 1.
- All comparisons and the +1 are unsigned CNT_W. No state other than cnt+1 crosses the counter width.
- Channels are fully independent except for the shared sync.

## Timing
- Async reset (reset=0): outclk=0, tick=0, pending=0, D=RESET_DIV, H=RESET_HIGH, cnt=0, SD/SH=0. Reset takes effect immediately, including mid-period.
- First edge after reset deasserts with enable=1: cnt==0 and D=2, so cnt<=1 and outclk<=(1<RESET_HIGH)=0.
- Enable rise: the first enabled edge is a wrap, so tick=1 and outclk=(H!=0) in the following cycle. Latency from the sampled enable to tick is 1 cycle.
- Enable fall: outclk and tick go low at the next edge.
- Load latency: a new SD/SH becomes active at the next wrap, sync, or disabled edge. The period in progress completes with the old values.
- sync: all enabled channels tick together in the cycle after sync is sampled. This restarts mid-period without any runt shorter than one inclk cycle.
- Output period = D inclk cycles; high time = min(H,D) cycles.

## Test plan
- D=4, H=2 on ch0, inclk 20 ns: outclk pattern 1100 repeating (80 ns period, 50% duty); tick high in each cycle where outclk rises.
- D=3, H=1 on ch1 and D=5, H=0 on ch2: ch1 pattern 100; ch2 outclk stays 0 while its tick pulses every 5 cycles.
- Ch0 running D=4/H=2 at cnt=1, load D=6/H=3: pending=1; the pattern finishes 00, then 111000 repeats and pending=0 at the boundary. A second load on the boundary cycle leaves pending=1.
- Ch0 D=4 and ch1 D=6 at different phases, pulse sync: both tick in the next cycle with outclk=1, and both patterns restart from cnt=0.
- Deassert enable[0] mid-high: outclk 0 at the next edge. Load D=8 while disabled: it applies immediately (pending=0). Re-enable: tick plus 8-cycle period.
- Assert reset=0 mid-period on all channels: outputs 0 immediately. On release, all channels run D=2/H=1 (pattern 01 from first edge).

Source files
------------

// File: rtl/clk_divider_bank_if.sv
// Control and status bundle for clk_divider_bank: per-channel enables, shadow
// loads and packed divisor/high-time buses in, divided clocks and flags out.
interface clk_divider_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 32
);
  logic [N_CH-1:0]       enable;
  logic                  sync;
  logic [N_CH-1:0]       load;
  logic [N_CH*CNT_W-1:0] divisor;
  logic [N_CH*CNT_W-1:0] high;
  logic [N_CH-1:0]       outclk;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       pending;

  modport master (
    output enable, sync, load, divisor, high,
    input  outclk, tick, pending
  );

  modport slave (
    input  enable, sync, load, divisor, high,
    output outclk, tick, pending
  );
endinterface

// File: rtl/clk_divider_bank.sv
// N_CH independent programmable clock dividers with double-buffered
// divisor/high-time, a period-start tick, and a shared phase-align strobe.
module clk_divider_bank #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 32,
  parameter int RESET_DIV  = 2,
  parameter int RESET_HIGH = 1
) (
  input  logic               inclk,
  input  logic               reset,
  clk_divider_bank_if.slave  bus
);

  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RESET_DIV);
  localparam logic [CNT_W-1:0] RST_H = CNT_W'(RESET_HIGH);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] d_reg, h_reg, sd_reg, sh_reg, cnt_reg;
    logic             pending_reg, outclk_reg, tick_reg;

    logic [CNT_W-1:0] d_app, h_app, idle_cnt;
    logic [CNT_W:0]   cnt_inc_wide;
    logic             wrap;

    // Post-apply values: the shadow wins only if it holds an unapplied update.
    always_comb begin
      d_app        = pending_reg ? sd_reg : d_reg;
      h_app        = pending_reg ? sh_reg : h_reg;
      idle_cnt     = (d_app <= ONE) ? '0 : d_app - ONE;
      cnt_inc_wide = {1'b0, cnt_reg} + (CNT_W + 1)'(1);
      wrap         = (d_reg <= ONE) || (cnt_reg == d_reg - ONE);
    end

    // A disabled channel parks its counter at the last count so that the
    // first enabled edge is a wrap and starts a clean period.
    always_ff @(posedge inclk or negedge reset) begin
      if (!reset) begin
        d_reg       <= RST_D;
        h_reg       <= RST_H;
        sd_reg      <= '0;
        sh_reg      <= '0;
        cnt_reg     <= '0;
        pending_reg <= 1'b0;
        outclk_reg  <= 1'b0;
        tick_reg    <= 1'b0;
      end else begin
        if (!bus.enable[gi]) begin
          d_reg       <= d_app;
          h_reg       <= h_app;
          pending_reg <= 1'b0;
          cnt_reg     <= idle_cnt;
          outclk_reg  <= 1'b0;
          tick_reg    <= 1'b0;
        end else if (bus.sync || wrap) begin
          d_reg       <= d_app;
          h_reg       <= h_app;
          pending_reg <= 1'b0;
          cnt_reg     <= '0;
          outclk_reg  <= (h_app != '0);
          tick_reg    <= 1'b1;
        end else begin
          cnt_reg     <= cnt_inc_wide[CNT_W-1:0];
          outclk_reg  <= (cnt_inc_wide < {1'b0, h_reg});
          tick_reg    <= 1'b0;
        end

        // A load on a boundary edge lands after the apply above, so the
        // freshly captured value stays pending for the next boundary.
        if (bus.load[gi]) begin
          sd_reg      <= bus.divisor[gi*CNT_W +: CNT_W];
          sh_reg      <= bus.high[gi*CNT_W +: CNT_W];
          pending_reg <= 1'b1;
        end
      end
    end

    assign bus.outclk[gi]  = outclk_reg;
    assign bus.tick[gi]    = tick_reg;
    assign bus.pending[gi] = pending_reg;
  end

endmodule

// File: tb/tb_clk_divider_bank.sv
// Directed and randomized bench for clk_divider_bank, compared every cycle
// against a position-in-period reference model.
module tb_clk_divider_bank;
  localparam int N_CH  = 4;
  localparam int CNT_W = 32;

  logic inclk;
  logic reset;

  clk_divider_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  clk_divider_bank #(
    .N_CH(N_CH), .CNT_W(CNT_W), .RESET_DIV(2), .RESET_HIGH(1)
  ) dut (
    .inclk (inclk),
    .reset (reset),
    .bus   (bus)
  );

  initial inclk = 1'b0;
  always #10 inclk = ~inclk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: where each channel sits in its period, plus active/shadow values.
  longint unsigned m_d   [N_CH];
  longint unsigned m_h   [N_CH];
  longint unsigned m_sd  [N_CH];
  longint unsigned m_sh  [N_CH];
  longint unsigned m_pos [N_CH];
  bit              m_pend[N_CH];
  bit              m_act [N_CH];

  task automatic check(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_d[i] = 2; m_h[i] = 1; m_sd[i] = 0; m_sh[i] = 0;
      m_pos[i] = 0; m_pend[i] = 0; m_act[i] = 0;
    end
  endtask

  task automatic model_apply(input int i);
    if (m_pend[i]) begin
      m_d[i] = m_sd[i]; m_h[i] = m_sh[i]; m_pend[i] = 0;
    end
  endtask

  task automatic model_step(input logic [N_CH-1:0] en, input logic sy, input logic [N_CH-1:0] ld,
                            input logic [N_CH*CNT_W-1:0] dv, input logic [N_CH*CNT_W-1:0] hi);
    for (int i = 0; i < N_CH; i++) begin
      bit at_end;
      at_end = (m_d[i] <= 1) || (m_pos[i] == m_d[i] - 1);
      if (!en[i]) begin
        model_apply(i);
        m_pos[i] = (m_d[i] <= 1) ? 0 : m_d[i] - 1;
        m_act[i] = 0;
      end else if (sy || at_end) begin
        model_apply(i);
        m_pos[i] = 0;
        m_act[i] = 1;
      end else begin
        m_pos[i] = m_pos[i] + 1;
        m_act[i] = 1;
      end
      if (ld[i]) begin
        m_sd[i] = longint'(dv[i*CNT_W +: CNT_W]);
        m_sh[i] = longint'(hi[i*CNT_W +: CNT_W]);
        m_pend[i] = 1;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    logic [N_CH-1:0] e_out, e_tick, e_pend;
    for (int i = 0; i < N_CH; i++) begin
      e_out[i]  = m_act[i] && (m_pos[i] < m_h[i]);
      e_tick[i] = m_act[i] && (m_pos[i] == 0);
      e_pend[i] = m_pend[i];
    end
    check({tag, ".outclk"},  bus.outclk,  e_out);
    check({tag, ".tick"},    bus.tick,    e_tick);
    check({tag, ".pending"}, bus.pending, e_pend);
  endtask

  task automatic edge_step(input string tag);
    logic [N_CH-1:0]       en, ld;
    logic                  sy;
    logic [N_CH*CNT_W-1:0] dv, hi;
    en = bus.enable; sy = bus.sync; ld = bus.load; dv = bus.divisor; hi = bus.high;
    @(posedge inclk);
    model_step(en, sy, ld, dv, hi);
    #1;
    compare_all(tag);
  endtask

  task automatic set_ch(input int i, input int unsigned d, input int unsigned h);
    bus.divisor[i*CNT_W +: CNT_W] = CNT_W'(d);
    bus.high[i*CNT_W +: CNT_W]    = CNT_W'(h);
  endtask

  initial begin
    logic [7:0] pat;
    reset = 1'b0;
    bus.enable = '0; bus.sync = 1'b0; bus.load = '0;
    bus.divisor = '0; bus.high = '0;
    model_reset();

    // Reset state
    @(posedge inclk); #1;
    compare_all("reset");
    check("reset.outclk_zero", bus.outclk, '0);
    reset = 1'b1;

    // All channels at reset defaults: first edge low, then 01 pattern
    bus.enable = '1;
    edge_step("rst_first");
    check("rst_first.outclk_zero", bus.outclk, '0);
    edge_step("rst_second");
    check("rst_second.outclk_high", bus.outclk, '1);
    for (int k = 0; k < 4; k++) edge_step("rst_run");

    // ch0 D=4/H=2, ch1 D=3/H=1, ch2 D=5/H=0
    set_ch(0, 4, 2); set_ch(1, 3, 1); set_ch(2, 5, 0);
    bus.load = 4'b0111;
    edge_step("load_a");
    bus.load = '0;
    for (int k = 0; k < 12; k++) edge_step("run_a");
    for (int k = 0; k < 8 && !bus.tick[0]; k++) edge_step("seek_tick0");
    check("seek_tick0.found", N_CH'(bus.tick[0]), N_CH'(1));
    pat = '0;
    for (int k = 0; k < 8; k++) begin
      pat = {pat[6:0], bus.outclk[0]};
      if (k < 7) edge_step("pat0");
    end
    check("pat0.1100", N_CH'(pat[7:4]), N_CH'(4'b1100));
    check("pat0.repeat", N_CH'(pat[3:0]), N_CH'(4'b1100));

    // Mid-period reload on ch0, then a second load on the boundary cycle
    for (int k = 0; k < 8 && m_pos[0] != 1; k++) edge_step("seek_cnt1");
    set_ch(0, 6, 3);
    bus.load = 4'b0001;
    edge_step("reload");
    bus.load = '0;
    check("reload.pending", N_CH'(bus.pending[0]), N_CH'(1));
    for (int k = 0; k < 8 && m_pos[0] != m_d[0] - 1; k++) edge_step("seek_end");
    set_ch(0, 6, 3);
    bus.load = 4'b0001;
    edge_step("boundary_load");
    bus.load = '0;
    check("boundary_load.pending", N_CH'(bus.pending[0]), N_CH'(1));
    for (int k = 0; k < 14; k++) edge_step("run_b");

    // Sync phase-aligns ch0 D=4 and ch1 D=6
    set_ch(0, 4, 2); set_ch(1, 6, 3);
    bus.load = 4'b0011;
    edge_step("load_sync");
    bus.load = '0;
    for (int k = 0; k < 9; k++) edge_step("dephase");
    bus.sync = 1'b1;
    edge_step("sync");
    bus.sync = 1'b0;
    check("sync.tick", N_CH'(bus.tick[1:0]), N_CH'(2'b11));
    check("sync.outclk", N_CH'(bus.outclk[1:0]), N_CH'(2'b11));
    for (int k = 0; k < 10; k++) edge_step("post_sync");

    // Disable ch0 mid-high, load while disabled, re-enable
    for (int k = 0; k < 8 && m_pos[0] != 0; k++) edge_step("seek_high");
    bus.enable[0] = 1'b0;
    edge_step("disable");
    check("disable.outclk0", N_CH'(bus.outclk[0]), N_CH'(0));
    set_ch(0, 8, 3);
    bus.load = 4'b0001;
    edge_step("load_idle");
    bus.load = '0;
    edge_step("idle_apply");
    check("idle_apply.pending0", N_CH'(bus.pending[0]), N_CH'(0));
    bus.enable[0] = 1'b1;
    edge_step("reenable");
    check("reenable.tick0", N_CH'(bus.tick[0]), N_CH'(1));
    for (int k = 0; k < 17; k++) edge_step("run_d8");

    // Asynchronous reset mid-period
    for (int k = 0; k < 3; k++) edge_step("pre_reset");
    reset = 1'b0;
    #2;
    model_reset();
    compare_all("async_reset");
    check("async_reset.tick_zero", bus.tick, '0);
    #3 reset = 1'b1;
    for (int k = 0; k < 6; k++) edge_step("post_reset");

    // Randomized traffic
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 19) == 0) bus.enable[$urandom_range(0, N_CH-1)] ^= 1'b1;
      bus.sync = ($urandom_range(0, 29) == 0);
      for (int i = 0; i < N_CH; i++) begin
        bus.load[i] = ($urandom_range(0, 11) == 0);
        set_ch(i, $urandom_range(0, 9),
               ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 10));
      end
      edge_step("random");
    end

    if (n_fail != 0) $display("%0d comparisons did not match", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
